// File: rtl/correlator_simple_if.sv
// Sample-in / result-out stream bundle for the binary-coefficient correlator.
interface correlator_simple_if #(
  parameter int INPUT_WIDTH  = 14,
  parameter int OUTPUT_WIDTH = 16
);
  logic                    Input_valid;
  logic [INPUT_WIDTH-1:0]  Input_data;
  logic                    Output_valid;
  logic [OUTPUT_WIDTH-1:0] Output_data;

  modport master (
    output Input_valid, Input_data,
    input  Output_valid, Output_data
  );

  modport slave (
    input  Input_valid, Input_data,
    output Output_valid, Output_data
  );
endinterface

// File: rtl/correlator_simple.sv
// Sliding-window binary-coefficient correlator: masked sum of the last L samples, top bits kept.
// Fixed LATENCY cycles per accepted sample, one result per input, no backpressure.
module correlator_simple #(
  parameter int CORRELATION_LENGTH = 64,
  parameter logic [0:CORRELATION_LENGTH-1] CORRELATION_DATA =
    64'b1111000011110000000000000000111100001111000000000000000000000000,
  parameter int LATENCY      = CORRELATION_LENGTH + 1,
  parameter int INPUT_WIDTH  = 14,
  parameter int OUTPUT_WIDTH = 16
) (
  input logic                Clk,
  input logic                Rst,
  correlator_simple_if.slave io
);
  localparam int LOG = $clog2(CORRELATION_LENGTH);
  localparam int P   = 1 << LOG;
  localparam int A   = INPUT_WIDTH + LOG;
  // Result stages after the tree root; LATENCY >= LOG+2 keeps this at least 1.
  localparam int D   = LATENCY - 1 - LOG;

  logic [INPUT_WIDTH-1:0]  win_q  [CORRELATION_LENGTH];
  logic [INPUT_WIDTH-1:0]  win_d  [CORRELATION_LENGTH];
  logic [A-1:0]            node_q [1:2*P-1];
  logic [A-1:0]            node_d [1:2*P-1];
  logic [LATENCY:0]        vld_q;
  logic [LATENCY:0]        vld_d;
  logic [OUTPUT_WIDTH-1:0] dly_q  [D];
  logic [OUTPUT_WIDTH-1:0] dly_d  [D];

  always_comb begin
    win_d = win_q;
    if (io.Input_valid) begin
      win_d[0] = io.Input_data;
      for (int i = 1; i < CORRELATION_LENGTH; i++) begin
        win_d[i] = win_q[i-1];
      end
    end
    vld_d = {vld_q[LATENCY-1:0], io.Input_valid};
  end

  // Heap-ordered adder tree: node j sums nodes 2j and 2j+1, one register level per depth.
  // Leaves P..2P-1 hold the masked window, w[0] (newest) paired with the rightmost coefficient bit.
  always_comb begin
    node_d = node_q;
    for (int i = 0; i < CORRELATION_LENGTH; i++) begin
      node_d[P+i] = CORRELATION_DATA[CORRELATION_LENGTH-1-i] ? {{LOG{1'b0}}, win_q[i]} : '0;
    end
    for (int i = CORRELATION_LENGTH; i < P; i++) begin
      node_d[P+i] = '0;
    end
    for (int j = 1; j < P; j++) begin
      node_d[j] = node_q[2*j] + node_q[2*j+1];
    end
  end

  // Tree output keeps updating between inputs; the last stage only loads on a real result.
  always_comb begin
    dly_d[0] = OUTPUT_WIDTH'(node_q[1] >> (A - OUTPUT_WIDTH));
    for (int k = 1; k < D; k++) begin
      dly_d[k] = dly_q[k-1];
    end
    if (!vld_q[LATENCY-1]) begin
      dly_d[D-1] = dly_q[D-1];
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      win_q  <= '{default: '0};
      node_q <= '{default: '0};
      vld_q  <= '0;
      dly_q  <= '{default: '0};
    end else begin
      win_q  <= win_d;
      node_q <= node_d;
      vld_q  <= vld_d;
      dly_q  <= dly_d;
    end
  end

  assign io.Output_valid = vld_q[LATENCY];
  assign io.Output_data  = dly_q[D-1];
endmodule

// File: tb/tb_correlator_simple.sv
// Bench for correlator_simple: impulse table, full scale, latency, random gaps and mid-stream reset.
module tb_correlator_simple;
  localparam int L   = 64;
  localparam int IW  = 14;
  localparam int OW  = 16;
  localparam int LAT = L + 1;
  localparam int AW  = 20;
  localparam logic [L-1:0] COEF =
    64'b1111000011110000000000000000111100001111000000000000000000000000;

  logic Clk = 1'b0;
  logic Rst = 1'b0;

  correlator_simple_if #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) bus ();

  correlator_simple dut (
    .Clk (Clk),
    .Rst (Rst),
    .io  (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [OW-1:0] dat;
    int            cyc;
  } exp_t;

  typedef struct {
    logic [IW-1:0] din;
    logic [OW-1:0] dout;
  } vec_t;

  exp_t   exp_q[$];
  vec_t   vecs[L];
  longint hist[L];
  int     cyc   = 0;
  int     n_cmp = 0;
  int     n_bad = 0;
  int     n_in  = 0;
  int     n_out = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: hist[0] is the newest sample; literal bit i (LSB numbering) weights hist[i].
  function automatic logic [OW-1:0] model_push(input longint d);
    longint s;
    s = 0;
    for (int i = L - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = d;
    for (int i = 0; i < L; i++) if (COEF[i]) s += hist[i];
    s = s & ((longint'(1) << AW) - 1);
    return OW'(s >> (AW - OW));
  endfunction

  task automatic send(input int d, input bit use_exp, input logic [OW-1:0] e);
    exp_t x;
    logic [OW-1:0] m;
    bus.Input_valid = 1'b1;
    bus.Input_data  = IW'(d);
    m     = model_push(longint'(d));
    x.dat = use_exp ? e : m;
    x.cyc = cyc + 1 + LAT;
    exp_q.push_back(x);
    n_in++;
    @(negedge Clk);
    bus.Input_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.Input_valid = 1'b0;
    repeat (n) @(negedge Clk);
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int i = 0; i < L; i++) hist[i] = 0;
    n_in  = 0;
    n_out = 0;
  endtask

  // Inputs toggle during reset; any that leaked in would later surface as stray outputs.
  task automatic do_reset(input int n);
    Rst = 1'b0;
    clear_model();
    repeat (n) begin
      bus.Input_valid = 1'($urandom_range(0, 1));
      bus.Input_data  = IW'($urandom);
      @(negedge Clk);
    end
    bus.Input_valid = 1'b0;
    Rst = 1'b1;
  endtask

  task automatic drain(input string tag);
    idle(LAT + 5);
    check({tag, "_left"}, exp_q.size(), 0);
    check({tag, "_count"}, n_out, n_in);
  endtask

  always @(negedge Clk) begin : monitor
    exp_t x;
    if (bus.Output_valid === 1'b1) begin
      n_out++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stray_output: got data %0d, required no output (cycle %0d)",
                 bus.Output_data, cyc);
      end else begin
        x = exp_q.pop_front();
        check("out_data", longint'(bus.Output_data), longint'(x.dat));
        check("out_cycle", cyc, x.cyc);
      end
    end
  end

  initial begin : timeout
    #2000000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    bus.Input_valid = 1'b0;
    bus.Input_data  = '0;

    for (int k = 0; k < L; k++) begin
      vecs[k].din  = (k == 0) ? IW'(16) : IW'(0);
      vecs[k].dout = ((k >= 24 && k <= 27) || (k >= 32 && k <= 35) ||
                      (k >= 52 && k <= 55) || (k >= 60)) ? OW'(1) : OW'(0);
    end

    @(negedge Clk);
    do_reset(100);
    for (int c = 0; c < 70; c++) begin
      check("idle_valid", bus.Output_valid, 0);
      check("idle_data", bus.Output_data, 0);
      @(negedge Clk);
    end

    // Impulse: checks coefficient bit order
    do_reset(4);
    for (int k = 0; k < L; k++) send(int'(vecs[k].din), 1'b1, vecs[k].dout);
    drain("impulse");

    do_reset(4);
    for (int k = 0; k < L; k++) send(16383, k == L - 1, OW'(16383));
    drain("fullscale");

    for (int k = 0; k < 100; k++) send(int'($urandom_range(0, 16383)), 1'b0, '0);
    drain("b2b");

    for (int k = 0; k < 10000; k++) begin
      send(int'($urandom_range(0, 16383)), 1'b0, '0);
      idle(int'($urandom_range(0, 5)));
    end
    drain("random");

    // Reset with results in flight and one being presented
    for (int k = 0; k < 70; k++) send(int'($urandom_range(0, 16383)), 1'b0, '0);
    #2;
    Rst = 1'b0;
    clear_model();
    #1;
    check("async_rst_valid", bus.Output_valid, 0);
    check("async_rst_data", bus.Output_data, 0);
    repeat (3) @(negedge Clk);
    Rst = 1'b1;
    for (int k = 0; k < 80; k++) begin
      send(int'($urandom_range(0, 16383)), 1'b0, '0);
      idle(int'($urandom_range(0, 2)));
    end
    drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/correlator_simple.md
# correlator_simple

Streaming binary-coefficient correlator for unsigned magnitude samples. It keeps a sliding window of the last CORRELATION_LENGTH accepted samples and sums the samples at the window positions whose coefficient bit is 1. It emits one truncated, fixed-latency result per accepted input. It sits after a magnitude detector to match a known on/off envelope pattern (e.g. preamble detection); upstream and downstream attach through simple valid/data streams with no backpressure.

## Interface
- CORRELATION_LENGTH, default 64: window length L (≥2).
- CORRELATION_DATA, default 64'b1111000011110000000000000000111100001111000000000000000000000000: coefficient vector declared [0 : L-1]; bit value 1 means include, 0 means exclude.
- LATENCY, default L+1: cycles from Input_valid to the matching Output_valid.
- INPUT_WIDTH, default 14: unsigned sample width.
- OUTPUT_WIDTH, default 16: result width; must be ≤ INPUT_WIDTH + clog2(L).
- Clk  in  1  clock; all logic is on the rising edge.
- Rst  in  1  asynchronous, active-low reset (0 = reset).
- Input_valid  in  1  sample strobe; may be high on any cycle, including back-to-back.
- Input_data  in  INPUT_WIDTH  unsigned sample, sampled when Input_valid=1.
- Output_valid  out  1  one-cycle strobe per result.
- Output_data  out  OUTPUT_WIDTH  correlation result, valid when Output_valid=1.

## Operation
- Window: w[0] is the newest accepted sample and w[L-1] the oldest. On each Input_valid, the window shifts by one and w[0] takes Input_data. Cycles without Input_valid leave the window unchanged. Gaps in the input stream are ignored.
- Coefficient mapping: w[i] is paired with CORRELATION_DATA[L-1-i]. The leftmost literal bit (index 0) weights the oldest sample; the rightmost bit weights the newest.
- Accumulator width A = INPUT_WIDTH + clog2(L). sum = Σ w[i]·CORRELATION_DATA[L-1-i], unsigned, modulo 2^A.
- Output_data = sum[A-1 : A-OUTPUT_WIDTH]. The low bits are truncated with no rounding and no saturation.
- The sum for input n includes sample n itself and the L-1 samples before it. Window positions never written since reset count as 0.
- There is exactly one output per input, in input order. No backpressure exists; the block accepts one sample per cycle.
- Implementation is free, e.g. a masked adder tree pipelined across LATENCY stages, with a valid shift register that has the same depth.

## Timing
- Input accepted at edge t gives Output_valid=1 for exactly one cycle, with the result, after edge t+LATENCY.
- The LATENCY value is fixed and independent of input gaps. A back-to-back input stream gives a back-to-back output stream.
- LATENCY must cover the adder-tree pipeline depth, with a minimum of clog2(L)+2. Any extra latency is padded with delay registers.
- Reset (Rst=0) takes effect immediately and asynchronously:
  - Output_valid becomes 0 and Output_data becomes 0.
  - All window registers and pipeline registers clear to 0.
  - In-flight results are discarded and never emitted.
- While Rst=0, Input_valid is ignored.
- After Rst is released, the first accepted sample sees an all-zero history.
- Output_data is don't-care when Output_valid=0; it holds its last value in the reference implementation.

## Test plan
- Reset/idle: hold Rst=0 for 100 cycles, then release with no input. Required: Output_valid stays 0 and Output_data stays 0.
- Impulse (defaults): after reset, send 16 followed by 63 zeros, back-to-back. Output k (k=0..63) must be:
  - 1 for k in 24–27, 32–35, 52–55 and 60–63;
  - 0 otherwise.
  This checks the coefficient bit order.
- Full scale: send 64 samples of 16383. Output 63 must be 16383 (16×16383=262128, shifted right by 4).
- Latency/throughput: send 100 back-to-back samples. Required: outputs appear back-to-back, each exactly LATENCY=65 cycles after its input.
- Random gaps: send 10000 random 14-bit samples with 0–5 idle cycles between them. Required: every output matches a software model of the window (shift on valid, masked sum, top 16 of 20 bits), and the output count equals the input count.
- Reset mid-stream: assert Rst while results are in flight, then restart. Required: no stale outputs, and the post-reset results match a model whose history is zero.
